// File: rtl/spi_flash_emu_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_emu_if
//  Description : SPI pin bundle between an SPI flash master and the
//                spi_flash_emu slave model. DQ0 is MOSI and DQ1 is MISO in
//                single-wire mode. DQ3..DQ0 carry data in quad mode.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_flash_emu_if;
    logic       spi_csn;
    logic       spi_sck;
    logic [3:0] spi_dq_i;
    logic [3:0] spi_dq_o;
    logic [3:0] spi_dq_oe;

    modport master (
        output spi_csn,
        output spi_sck,
        output spi_dq_i,
        input  spi_dq_o,
        input  spi_dq_oe
    );

    modport slave (
        input  spi_csn,
        input  spi_sck,
        input  spi_dq_i,
        output spi_dq_o,
        output spi_dq_oe
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_emu.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_emu
//  Description : SPI NOR flash slave emulator (N25Q/M25P-style subset).
//                The SPI pins are oversampled on the system clock, which must
//                run at least 8x SCK. Supported opcodes: 9F RDID, 05 RDSR,
//                06 WREN, 04 WRDI, 03 READ, 02 PP. Define QUAD_IO_EN to
//                add 6B quad output fast read; DUMMY_CYCLES must then be >= 1.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_flash_emu #(
    parameter int          ADDR_BITS    = 8,
    parameter logic [23:0] JEDEC_ID     = 24'h20BA16,
    parameter int          PROG_CYCLES  = 64,
    parameter int          DUMMY_CYCLES = 8
) (
    input  wire            clock,
    input  wire            rst_n,
    spi_flash_emu_if.slave spi
);

`ifdef QUAD_IO_EN
    localparam bit         c_quad_en = 1'b1;
    localparam logic [3:0] c_oe_mask = 4'b1111;
`else
    localparam bit         c_quad_en = 1'b0;
    localparam logic [3:0] c_oe_mask = 4'b0010;
`endif

    localparam int                   c_depth     = 1 << ADDR_BITS;
    localparam int                   c_page_bits = (ADDR_BITS < 8) ? ADDR_BITS : 8;
    localparam logic [ADDR_BITS-1:0] c_page_mask = ADDR_BITS'((64'd1 << c_page_bits) - 64'd1);
    localparam int                   c_wip_w     = $clog2(PROG_CYCLES + 1);

    localparam logic [7:0] c_op_pp    = 8'h02;
    localparam logic [7:0] c_op_read  = 8'h03;
    localparam logic [7:0] c_op_wrdi  = 8'h04;
    localparam logic [7:0] c_op_rdsr  = 8'h05;
    localparam logic [7:0] c_op_wren  = 8'h06;
    localparam logic [7:0] c_op_qread = 8'h6B;
    localparam logic [7:0] c_op_rdid  = 8'h9F;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_ADDR     = 3'd2,
        S_DUMMY    = 3'd3,
        S_DATA_IN  = 3'd4,
        S_DATA_OUT = 3'd5,
        S_HOLD     = 3'd6
    } state_t;

    // Pin synchronizers and SCK edge history
    logic       r_csn_s1, r_csn_s2;
    logic       r_sck_s1, r_sck_s2, r_sck_d;
    logic [3:0] r_dq_s1, r_dq_s2;

    // Protocol state
    state_t                r_state;
    logic [7:0]            r_cnt;
    logic [7:0]            r_cmd;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [7:0]            r_shift;
    logic [7:0]            r_out_byte;
    logic [1:0]            r_idx;
    logic [3:0]            r_dq_o;
    logic [3:0]            r_dq_oe;
    logic                  r_wip;
    logic                  r_wel;
    logic [c_wip_w-1:0]    r_wip_cnt;
    logic                  r_pend_wren;
    logic                  r_pend_wrdi;
    logic                  r_pend_prog;
    logic                  r_mem_we;
    logic [ADDR_BITS-1:0]  r_mem_waddr;
    logic [7:0]            r_mem_wdata;

    // Erased flash content exists from configuration; reset never touches it
    logic [7:0] r_mem [c_depth] = '{default: 8'hFF};

    logic                 w_sck_rise;
    logic                 w_sck_fall;
    logic                 w_din;
    logic [7:0]           w_cmd_full;
    logic [ADDR_BITS-1:0] w_addr_full;
    logic [ADDR_BITS-1:0] w_addr_inc;
    logic [ADDR_BITS-1:0] w_addr_pp;
    logic [7:0]           w_status;
    logic [7:0]           w_rd_first;
    logic [7:0]           w_rd_cur;
    logic [7:0]           w_next_byte;
    logic                 w_quad;
    logic                 w_unused;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
    assign w_din       = r_dq_s2[0];
    assign w_cmd_full  = {r_cmd[6:0], w_din};
    assign w_addr_full = {r_addr[ADDR_BITS-2:0], w_din};
    assign w_addr_inc  = r_addr + ADDR_BITS'(1);
    // Page program stays inside its 256-byte page
    assign w_addr_pp   = (r_addr & ~c_page_mask) | (w_addr_inc & c_page_mask);
    assign w_status    = {6'b000000, r_wel, r_wip};
    assign w_rd_first  = r_mem[w_addr_full];
    assign w_rd_cur    = r_mem[r_addr];
    assign w_quad      = c_quad_en && (r_cmd == c_op_qread);
    // Only DQ0 is ever an input; the other synchronized pins are unused
    assign w_unused    = ^r_dq_s2[3:1];

    assign spi.spi_dq_o  = r_dq_o;
    assign spi.spi_dq_oe = r_dq_oe & c_oe_mask;

    // Byte to present once the current output byte has been fully shifted
    always_comb begin
        w_next_byte = 8'h00;
        case (r_cmd)
            c_op_rdid: begin
                case (r_idx)
                    2'd0:    w_next_byte = JEDEC_ID[15:8];
                    2'd1:    w_next_byte = JEDEC_ID[7:0];
                    default: w_next_byte = 8'h00;
                endcase
            end
            c_op_rdsr: w_next_byte = w_status;
            default:   w_next_byte = r_mem[w_addr_inc];
        endcase
    end

    // Two-flop synchronizers on all SPI inputs plus SCK edge history
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_csn_s1 <= 1'b1;
            r_csn_s2 <= 1'b1;
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_d  <= 1'b0;
            r_dq_s1  <= 4'h0;
            r_dq_s2  <= 4'h0;
        end else begin
            r_csn_s1 <= spi.spi_csn;
            r_csn_s2 <= r_csn_s1;
            r_sck_s1 <= spi.spi_sck;
            r_sck_s2 <= r_sck_s1;
            r_sck_d  <= r_sck_s2;
            r_dq_s1  <= spi.spi_dq_i;
            r_dq_s2  <= r_dq_s1;
        end
    end

    // Command FSM, status register, program timer and registered pin outputs
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_cmd       <= 8'h00;
            r_addr      <= '0;
            r_shift     <= 8'h00;
            r_out_byte  <= 8'h00;
            r_idx       <= 2'd0;
            r_dq_o      <= 4'h0;
            r_dq_oe     <= 4'h0;
            r_wip       <= 1'b0;
            r_wel       <= 1'b0;
            r_wip_cnt   <= '0;
            r_pend_wren <= 1'b0;
            r_pend_wrdi <= 1'b0;
            r_pend_prog <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= 8'h00;
        end else begin
            r_mem_we <= 1'b0;

            if (r_wip) begin
                if (r_wip_cnt == c_wip_w'(1)) begin
                    r_wip     <= 1'b0;
                    r_wel     <= 1'b0;
                    r_wip_cnt <= '0;
                end else begin
                    r_wip_cnt <= r_wip_cnt - c_wip_w'(1);
                end
            end

            if (r_csn_s2) begin
                // Deselected: release the bus and commit whatever the command earned
                r_state     <= S_IDLE;
                r_cnt       <= 8'd0;
                r_dq_o      <= 4'h0;
                r_dq_oe     <= 4'h0;
                r_pend_wren <= 1'b0;
                r_pend_wrdi <= 1'b0;
                r_pend_prog <= 1'b0;
                if (r_pend_wren) r_wel <= 1'b1;
                if (r_pend_wrdi) r_wel <= 1'b0;
                if (r_pend_prog) begin
                    r_wip     <= 1'b1;
                    r_wip_cnt <= c_wip_w'(PROG_CYCLES);
                end
            end else begin
                case (r_state)
                    S_IDLE, S_CMD: begin
                        r_state <= S_CMD;
                        if (w_sck_rise) begin
                            r_cmd <= w_cmd_full;
                            r_cnt <= r_cnt + 8'd1;
                            if (r_cnt == 8'd7) begin
                                r_cnt <= 8'd0;
                                r_idx <= 2'd0;
                                if (w_cmd_full == c_op_rdid) begin
                                    r_out_byte <= JEDEC_ID[23:16];
                                    r_dq_o     <= {2'b00, JEDEC_ID[23], 1'b0};
                                    r_dq_oe    <= 4'b0010;
                                    r_state    <= S_DATA_OUT;
                                end else if (w_cmd_full == c_op_rdsr) begin
                                    r_out_byte <= w_status;
                                    r_dq_o     <= {2'b00, w_status[7], 1'b0};
                                    r_dq_oe    <= 4'b0010;
                                    r_state    <= S_DATA_OUT;
                                end else if (r_wip) begin
                                    r_state <= S_HOLD;
                                end else begin
                                    case (w_cmd_full)
                                        c_op_wren: begin
                                            r_pend_wren <= 1'b1;
                                            r_state     <= S_HOLD;
                                        end
                                        c_op_wrdi: begin
                                            r_pend_wrdi <= 1'b1;
                                            r_state     <= S_HOLD;
                                        end
                                        c_op_read:  r_state <= S_ADDR;
                                        c_op_pp:    r_state <= r_wel ? S_ADDR : S_HOLD;
                                        c_op_qread: r_state <= c_quad_en ? S_ADDR : S_HOLD;
                                        default:    r_state <= S_HOLD;
                                    endcase
                                end
                            end
                        end
                    end

                    S_ADDR: begin
                        if (w_sck_rise) begin
                            r_addr <= w_addr_full;
                            r_cnt  <= r_cnt + 8'd1;
                            if (r_cnt == 8'd23) begin
                                r_cnt <= 8'd0;
                                if (r_cmd == c_op_read) begin
                                    r_out_byte <= w_rd_first;
                                    r_dq_o     <= {2'b00, w_rd_first[7], 1'b0};
                                    r_dq_oe    <= 4'b0010;
                                    r_state    <= S_DATA_OUT;
                                end else if (r_cmd == c_op_pp) begin
                                    r_state <= S_DATA_IN;
                                end else begin
                                    r_state <= S_DUMMY;
                                end
                            end
                        end
                    end

                    S_DUMMY: begin
                        if (w_sck_rise) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (r_cnt == 8'(DUMMY_CYCLES - 1)) begin
                                r_cnt      <= 8'd0;
                                r_out_byte <= w_rd_cur;
                                r_dq_o     <= w_rd_cur[7:4];
                                r_dq_oe    <= 4'hF;
                                r_state    <= S_DATA_OUT;
                            end
                        end
                    end

                    S_DATA_IN: begin
                        if (w_sck_rise) begin
                            r_shift <= {r_shift[6:0], w_din};
                            r_cnt   <= r_cnt + 8'd1;
                            // Only whole bytes reach the array; a trailing fragment never does
                            if (r_cnt[2:0] == 3'd7) begin
                                r_mem_we    <= 1'b1;
                                r_mem_waddr <= r_addr;
                                r_mem_wdata <= {r_shift[6:0], w_din};
                                r_addr      <= w_addr_pp;
                                r_pend_prog <= 1'b1;
                            end
                        end
                    end

                    S_DATA_OUT: begin
                        if (w_sck_rise) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (w_quad ? r_cnt[0] : (r_cnt[2:0] == 3'd7)) begin
                                r_out_byte <= w_next_byte;
                                r_addr     <= w_addr_inc;
                                if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
                            end
                        end else if (w_sck_fall) begin
                            // The fall right after entry re-drives the first bit, which keeps it stable
                            if (w_quad) begin
                                r_dq_o <= r_cnt[0] ? r_out_byte[3:0] : r_out_byte[7:4];
                            end else begin
                                r_dq_o <= {2'b00, r_out_byte[3'd7 - r_cnt[2:0]], 1'b0};
                            end
                        end
                    end

                    S_HOLD: begin
                        // Any bit past the opcode voids a pending WREN/WRDI
                        if (w_sck_rise) begin
                            r_pend_wren <= 1'b0;
                            r_pend_wrdi <= 1'b0;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Flash array write: programming can only clear bits
    always_ff @(posedge clock) begin
        if (r_mem_we) begin
            r_mem[r_mem_waddr] <= r_mem[r_mem_waddr] & r_mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_emu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_flash_emu
//  Description : Self-checking bench for spi_flash_emu. A byte-array flash
//                model with WEL/WIP flags predicts every response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_flash_emu;
    localparam int HALF = 4;
    localparam int PROG = 1000;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    spi_flash_emu_if bus();

    spi_flash_emu #(
        .ADDR_BITS   (8),
        .JEDEC_ID    (24'h20BA16),
        .PROG_CYCLES (PROG),
        .DUMMY_CYCLES(8)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .spi  (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference flash model
    logic [7:0] m_mem [256];
    bit         m_wel;
    bit         m_wip;

    logic [7:0] tx_q[$];
    logic       rx_bits[$];
    logic [3:0] rx_nib[$];
    logic [3:0] rx_oe[$];

    // One chip-select framed transfer of nbits SCK cycles, MOSI from tx_q
    task automatic xfer(input int nbits);
        rx_bits.delete();
        rx_nib.delete();
        rx_oe.delete();
        @(negedge clock);
        bus.spi_csn = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            int bi;
            bi = i / 8;
            bus.spi_dq_i = {3'b000, (bi < tx_q.size()) ? tx_q[bi][7 - (i % 8)] : 1'b0};
            repeat (HALF) @(negedge clock);
            rx_bits.push_back(bus.spi_dq_o[1]);
            rx_nib.push_back(bus.spi_dq_o);
            rx_oe.push_back(bus.spi_dq_oe);
            bus.spi_sck = 1'b1;
            repeat (HALF) @(negedge clock);
            bus.spi_sck = 1'b0;
        end
        repeat (HALF) @(negedge clock);
        bus.spi_csn  = 1'b1;
        bus.spi_dq_i = 4'h0;
        repeat (8) @(negedge clock);
    endtask

    function automatic logic [7:0] rx_byte(input int first);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) b = {b[6:0], rx_bits[first + k]};
        return b;
    endfunction

    task automatic put_addr(input logic [7:0] op, input logic [23:0] addr);
        tx_q.delete();
        tx_q.push_back(op);
        tx_q.push_back(addr[23:16]);
        tx_q.push_back(addr[15:8]);
        tx_q.push_back(addr[7:0]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clock);
        rst_n = 1'b1;
        repeat (4) @(negedge clock);
        m_wel = 1'b0;
        m_wip = 1'b0;
    endtask

    task automatic op_bits(input logic [7:0] op, input int nbits);
        tx_q.delete();
        tx_q.push_back(op);
        xfer(nbits);
        if (nbits == 8 && !m_wip) begin
            if (op == 8'h06) m_wel = 1'b1;
            if (op == 8'h04) m_wel = 1'b0;
        end
    endtask

    task automatic op_pp(input logic [23:0] addr, input logic [7:0] data[$], input int extra);
        int a;
        put_addr(8'h02, addr);
        foreach (data[k]) tx_q.push_back(data[k]);
        xfer(32 + 8 * data.size() + extra);
        if (m_wel && !m_wip && data.size() > 0) begin
            a = int'(addr[7:0]);
            foreach (data[k]) begin
                m_mem[a] = m_mem[a] & data[k];
                a = (a & ~255) | ((a + 1) & 255);
            end
            m_wip = 1'b1;
        end
    endtask

    task automatic wait_prog();
        repeat (PROG + 20) @(negedge clock);
        if (m_wip) begin
            m_wip = 1'b0;
            m_wel = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.spi_dq_oe !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_oe: got %h expected 0", bus.spi_dq_oe);
        end
        n_checks++;
        if (bus.spi_dq_o !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_dq_o: got %h expected 0", bus.spi_dq_o);
        end
    endtask

    task automatic test_rdid();
        logic [7:0] exp_id [5];
        exp_id = '{8'h20, 8'hBA, 8'h16, 8'h00, 8'h00};
        op_bits(8'h9F, 48);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (rx_byte(8 + 8 * k) !== exp_id[k]) begin
                n_errors++;
                $display("FAIL rdid_byte%0d: got %h expected %h", k, rx_byte(8 + 8 * k), exp_id[k]);
            end
        end
        n_checks++;
        if (rx_oe[8] !== 4'b0010 || rx_oe[47] !== 4'b0010) begin
            n_errors++;
            $display("FAIL rdid_oe: got %h/%h expected 2", rx_oe[8], rx_oe[47]);
        end
    endtask

    task automatic rdsr_check(input string name, input int nbytes);
        logic [7:0] exp;
        exp = {6'b000000, m_wel, m_wip};
        op_bits(8'h05, 8 + 8 * nbytes);
        for (int k = 0; k < nbytes; k++) begin
            n_checks++;
            if (rx_byte(8 + 8 * k) !== exp) begin
                n_errors++;
                $display("FAIL %s_b%0d: got %h expected %h", name, k, rx_byte(8 + 8 * k), exp);
            end
        end
    endtask

    task automatic read_check(input string name, input logic [23:0] addr, input int n);
        int a;
        put_addr(8'h03, addr);
        xfer(32 + 8 * n);
        a = int'(addr[7:0]);
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (rx_byte(32 + 8 * k) !== m_mem[a]) begin
                n_errors++;
                $display("FAIL %s[%0d]: got %h expected %h", name, k, rx_byte(32 + 8 * k), m_mem[a]);
            end
            a = (a + 1) % 256;
        end
    endtask

    task automatic test_status();
        rdsr_check("rdsr_reset", 1);
        op_bits(8'h06, 8);
        rdsr_check("rdsr_wren", 1);
        op_bits(8'h04, 8);
        rdsr_check("rdsr_wrdi", 1);
    endtask

    task automatic test_page_program();
        logic [7:0] data[$];
        bit         any_oe;
        for (int k = 0; k < 256; k++) data.push_back(8'(255 - k));
        op_bits(8'h06, 8);
        op_pp(24'h000000, data, 0);
        rdsr_check("rdsr_busy", 2);
        // READ while busy must be ignored with the bus released
        put_addr(8'h03, 24'h000000);
        xfer(40);
        any_oe = 1'b0;
        foreach (rx_oe[k]) if (rx_oe[k] !== 4'h0) any_oe = 1'b1;
        n_checks++;
        if (any_oe) begin
            n_errors++;
            $display("FAIL read_while_busy: got oe active expected 0");
        end
        wait_prog();
        rdsr_check("rdsr_done", 1);
        read_check("pp_read", 24'h000000, 256);
    endtask

    task automatic test_pp_rules();
        logic [7:0] data[$];
        data.push_back(8'h00);
        op_pp(24'h000010, data, 0);
        read_check("pp_no_wel", 24'h000010, 1);
        data.delete();
        data.push_back(8'h0F);
        op_bits(8'h06, 8);
        op_pp(24'h00000F, data, 0);
        wait_prog();
        read_check("pp_and", 24'h00000F, 1);
        n_checks++;
        if (m_mem[8'h0F] !== 8'h00) begin
            n_errors++;
            $display("FAIL pp_and_model: got %h expected 00", m_mem[8'h0F]);
        end
    endtask

    task automatic test_abort_wrap();
        op_bits(8'h06, 5);
        rdsr_check("rdsr_abort", 1);
        read_check("read_wrap", 24'h0000FF, 2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] data[$];
        data.push_back(8'h5A);
        op_bits(8'h06, 8);
        op_pp(24'h000080, data, 0);
        do_reset();
        rdsr_check("rdsr_after_rst", 1);
        read_check("mem_kept", 24'h000080, 1);
    endtask

    task automatic test_quad();
`ifdef QUAD_IO_EN
        logic [3:0] exp_nib [4];
        exp_nib = '{m_mem[0][7:4], m_mem[0][3:0], m_mem[1][7:4], m_mem[1][3:0]};
        put_addr(8'h6B, 24'h000000);
        xfer(44);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rx_nib[40 + k] !== exp_nib[k] || rx_oe[40 + k] !== 4'hF) begin
                n_errors++;
                $display("FAIL quad_nib%0d: got %h oe %h expected %h oe f", k, rx_nib[40 + k], rx_oe[40 + k], exp_nib[k]);
            end
        end
`else
        bit any_oe;
        put_addr(8'h6B, 24'h000000);
        xfer(48);
        any_oe = 1'b0;
        foreach (rx_oe[k]) if (rx_oe[k] !== 4'h0) any_oe = 1'b1;
        n_checks++;
        if (any_oe) begin
            n_errors++;
            $display("FAIL quad_unknown: got oe active expected 0");
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0]  data[$];
        logic [23:0] addr;
        int          bad_bits;
        for (int it = 0; it < 4; it++) begin
            bad_bits = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(9, 12);
            op_bits(8'h06, bad_bits);
            rdsr_check("rand_badwren", 1);
            data.delete();
            repeat ($urandom_range(1, 6)) data.push_back(8'($urandom));
            addr = 24'($urandom);
            op_bits(8'h06, 8);
            op_pp(addr, data, $urandom_range(0, 7));
            wait_prog();
            rdsr_check("rand_idle", 1);
            read_check("rand_pp", addr, data.size());
            read_check("rand_read", 24'($urandom), $urandom_range(1, 6));
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) m_mem[k] = 8'hFF;
        m_wel        = 1'b0;
        m_wip        = 1'b0;
        bus.spi_csn  = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_dq_i = 4'h0;
        test_reset();
        test_rdid();
        test_status();
        test_page_program();
        test_pp_rules();
        test_abort_wrap();
        test_reset_mid();
        test_quad();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
